// File: rtl/clkdiv_multi_pkg.sv
// clkdiv_multi_pkg: shared defaults and divisor helper functions for the
// multi-channel fabric clock divider.
// Optional build macro: CLKDIV_MULTI_CALIB_EN (enables calib phase-slip logic).
package clkdiv_multi_pkg;

  // Default divisor width; the largest usable divisor is 2^DIV_W-1.
  localparam int DEF_DIV_W = 8;

  // Divisor every channel runs with straight out of reset.
  localparam int DEF_DEFAULT_DIV = 4;

  // Smallest divisor that still produces a real clock (one high, one low).
  localparam int unsigned MIN_DIV = 32'd2;

  // Requested divisors of 0 or 1 cannot form a period; treat them as 2.
  function automatic int unsigned clamp_div(input int unsigned value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

  // Number of high cycles in a period of n; odd n gets the extra cycle high.
  function automatic int unsigned high_len(input int unsigned n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_multi_chan.sv
// clkdiv_multi_chan: one divider channel. Holds the period counter, the
// active and pending divisors and the optional calib slip logic. All outputs
// are registered and aligned with the counter value they describe.
// Optional build macro: CLKDIV_MULTI_CALIB_EN (calib rising edge holds cnt
// for one cycle; when undefined calib is ignored and cnt never holds).
module clkdiv_multi_chan
  import clkdiv_multi_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             hclkin,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div_value,
  input  logic             div_load,
  input  logic             calib,
  output logic             clkout,
  output logic             ce,
  output logic             div_ack,
  output logic             div_pending
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_reg,     cnt_next;
  logic [DIV_W-1:0] active_reg,  active_next;
  logic [DIV_W-1:0] pending_reg, pending_next;
  logic             pending_valid_reg, pending_valid_next;
  logic             clkout_reg, clkout_next;
  logic             ce_reg,     ce_next;
  logic             ack_reg,    ack_next;
  logic [DIV_W-1:0] load_div;
  logic             hold;

  // Clamped form of the requested divisor, ready to drop into pending.
  assign load_div = DIV_W'(clamp_div(32'(div_value)));

`ifdef CLKDIV_MULTI_CALIB_EN
  logic calib_d_reg;

  // Remember the previous calib sample so only a rising edge slips the phase.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      calib_d_reg <= 1'b0;
    end else begin
      calib_d_reg <= calib;
    end
  end

  assign hold = calib & ~calib_d_reg;
`else
  logic calib_unused;

  assign calib_unused = calib;
  assign hold         = 1'b0;
`endif

  // Next counter, divisor handover at the wrap, and the output values that
  // will describe the next counter value.
  always_comb begin
    cnt_next           = cnt_reg + ONE;
    active_next        = active_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    ack_next           = 1'b0;

    if (hold) begin
      // Slip cycle: freeze the phase, including any wrap due this cycle.
      cnt_next = cnt_reg;
    end else if (cnt_reg == active_reg - ONE) begin
      cnt_next = '0;
      if (pending_valid_reg) begin
        active_next        = pending_reg;
        pending_valid_next = 1'b0;
        ack_next           = 1'b1;
      end
    end

    // A load on the wrap edge lands after the handover above, so it waits a
    // full period; a second load before the wrap simply overwrites.
    if (div_load) begin
      pending_next       = load_div;
      pending_valid_next = 1'b1;
    end

    ce_next     = !hold && (cnt_next == active_next - ONE);
    clkout_next = hold ? clkout_reg
                       : (32'(cnt_next) < high_len(32'(active_next)));
  end

  // State and output registers.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      cnt_reg           <= '0;
      active_reg        <= RST_DIV;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      clkout_reg        <= 1'b0;
      ce_reg            <= 1'b0;
      ack_reg           <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      active_reg        <= active_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      clkout_reg        <= clkout_next;
      ce_reg            <= ce_next;
      ack_reg           <= ack_next;
    end
  end

  assign clkout      = clkout_reg;
  assign ce          = ce_reg;
  assign div_ack     = ack_reg;
  assign div_pending = pending_valid_reg;

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CHANNELS independent programmable clock dividers running
// from the single fast clock hclkin. Each channel gets its own slice of
// div_value and its own load / calib strobes.
// Optional build macro: CLKDIV_MULTI_CALIB_EN (enables calib phase slips).
module clkdiv_multi
  import clkdiv_multi_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic                      hclkin,
  input  logic                      resetn,
  input  logic [CHANNELS*DIV_W-1:0] div_value,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic [CHANNELS-1:0]       calib,
  output logic [CHANNELS-1:0]       clkout,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       div_ack,
  output logic [CHANNELS-1:0]       div_pending
);

  genvar gi;

  // One self-contained divider per channel; no shared state between them.
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      clkdiv_multi_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .hclkin      (hclkin),
        .resetn      (resetn),
        .div_value   (div_value[gi*DIV_W +: DIV_W]),
        .div_load    (div_load[gi]),
        .calib       (calib[gi]),
        .clkout      (clkout[gi]),
        .ce          (ce[gi]),
        .div_ack     (div_ack[gi]),
        .div_pending (div_pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: self-checking bench for clkdiv_multi (2 channels, 8-bit
// divisors, default divisor 4). A period-level reference model runs beside
// the DUT every cycle; directed tables and short sequences pin the corners.
module tb_clkdiv_multi;

  localparam int CH  = 2;
  localparam int DW  = 8;
  localparam int DEF = 4;

`ifdef CLKDIV_MULTI_CALIB_EN
  localparam bit CAL_EN = 1'b1;
`else
  localparam bit CAL_EN = 1'b0;
`endif

  logic             hclkin = 1'b0;
  logic             resetn = 1'b1;
  logic [CH*DW-1:0] div_value;
  logic [CH-1:0]    div_load;
  logic [CH-1:0]    calib;
  logic [CH-1:0]    clkout;
  logic [CH-1:0]    ce;
  logic [CH-1:0]    div_ack;
  logic [CH-1:0]    div_pending;

  clkdiv_multi #(
    .CHANNELS    (CH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .hclkin      (hclkin),
    .resetn      (resetn),
    .div_value   (div_value),
    .div_load    (div_load),
    .calib       (calib),
    .clkout      (clkout),
    .ce          (ce),
    .div_ack     (div_ack),
    .div_pending (div_pending)
  );

  always #5 hclkin = ~hclkin;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Reference model: position inside the current period and period length.
  int m_pos[CH];
  int m_per[CH];
  int m_pend[CH];
  bit m_pv[CH];
  bit m_prev[CH];
  bit m_clk[CH];
  bit m_ce[CH];
  bit m_ack[CH];

  typedef struct {
    logic [CH-1:0] load;
    logic [DW-1:0] v0;
    logic [CH-1:0] clk;
    logic [CH-1:0] ce;
    logic [CH-1:0] ack;
    logic [CH-1:0] pend;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic [CH-1:0] load, input int v0,
                              input logic [CH-1:0] c, input logic [CH-1:0] e,
                              input logic [CH-1:0] a, input logic [CH-1:0] p);
    vec_t r;
    r.load = load; r.v0 = DW'(v0); r.clk = c; r.ce = e; r.ack = a; r.pend = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b required %b", name, edge_no, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_per[c] = DEF; m_pend[c] = 0; m_pv[c] = 0;
      m_prev[c] = 0; m_clk[c] = 0; m_ce[c] = 0; m_ack[c] = 0;
    end
  endtask

  // One hclkin edge of the reference: advance the phase, hand over the
  // pending divisor at the end of a period, then capture any new load.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit slip;
      int v;
      slip = CAL_EN && calib[c] && !m_prev[c];
      m_prev[c] = calib[c];
      m_ack[c] = 0;
      if (slip) begin
        m_ce[c] = 0;
      end else begin
        m_pos[c] = m_pos[c] + 1;
        if (m_pos[c] == m_per[c]) begin
          m_pos[c] = 0;
          if (m_pv[c]) begin
            m_per[c] = m_pend[c];
            m_pv[c] = 0;
            m_ack[c] = 1;
          end
        end
        m_ce[c]  = (m_pos[c] == m_per[c] - 1);
        m_clk[c] = (m_pos[c] < (m_per[c] + 1) / 2);
      end
      if (div_load[c]) begin
        v = int'(div_value[c*DW +: DW]);
        m_pend[c] = (v < 2) ? 2 : v;
        m_pv[c] = 1;
      end
    end
  endtask

  // Advance one clock, step the model, compare all outputs 1 time unit later.
  task automatic tick();
    logic [CH-1:0] e_clk, e_ce, e_ack, e_pv;
    @(posedge hclkin);
    model_step();
    edge_no++;
    #1;
    for (int c = 0; c < CH; c++) begin
      e_clk[c] = m_clk[c]; e_ce[c] = m_ce[c]; e_ack[c] = m_ack[c]; e_pv[c] = m_pv[c];
    end
    check("clkout", clkout, e_clk);
    check("ce", ce, e_ce);
    check("div_ack", div_ack, e_ack);
    check("div_pending", div_pending, e_pv);
  endtask

  // Assert reset away from the clock edge, confirm outputs clear at once,
  // then release so that the next rising edge is edge 1.
  task automatic apply_reset();
    #2;
    resetn   = 1'b0;
    div_load = '0;
    calib    = '0;
    #1;
    check("rst_clkout", clkout, '0);
    check("rst_ce", ce, '0);
    check("rst_div_ack", div_ack, '0);
    check("rst_div_pending", div_pending, '0);
    model_reset();
    @(posedge hclkin);
    @(posedge hclkin);
    #4;
    resetn  = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    int ack_n, ack_e, ack1_e, ce_n, ce1_n, ce_e1, ce_e2, hi_n, ch1_ce;

    // Edges 1..12: defaults after reset. Edges 13..22: ch0 loaded with 6.
    tbl[0]  = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[3]  = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[5]  = mk(2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[6]  = mk(2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[7]  = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[8]  = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[9]  = mk(2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[10] = mk(2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[11] = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[12] = mk(2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[13] = mk(2'b01, 6, 2'b00, 2'b00, 2'b00, 2'b01);
    tbl[14] = mk(2'b00, 6, 2'b00, 2'b11, 2'b00, 2'b01);
    tbl[15] = mk(2'b00, 6, 2'b11, 2'b00, 2'b01, 2'b00);
    tbl[16] = mk(2'b00, 6, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[17] = mk(2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);
    tbl[18] = mk(2'b00, 6, 2'b00, 2'b10, 2'b00, 2'b00);
    tbl[19] = mk(2'b00, 6, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[20] = mk(2'b00, 6, 2'b10, 2'b01, 2'b00, 2'b00);
    tbl[21] = mk(2'b00, 6, 2'b01, 2'b00, 2'b00, 2'b00);

    div_value = '0;
    div_load  = '0;
    calib     = '0;
    apply_reset();

    for (int i = 0; i < 22; i++) begin
      div_load = tbl[i].load;
      div_value[DW-1:0] = tbl[i].v0;
      tick();
      div_load = '0;
      check("tbl_clkout", clkout, tbl[i].clk);
      check("tbl_ce", ce, tbl[i].ce);
      check("tbl_div_ack", div_ack, tbl[i].ack);
      check("tbl_div_pending", div_pending, tbl[i].pend);
    end

    // Two loads in one period: 8 then 3; only 3 takes effect, one ack.
    apply_reset();
    ack_n = 0; ack_e = 0; ce_n = 0;
    for (int k = 1; k <= 16; k++) begin
      div_load = '0;
      if (k == 1) begin div_load[0] = 1'b1; div_value[DW-1:0] = 8'd8; end
      if (k == 2) begin div_load[0] = 1'b1; div_value[DW-1:0] = 8'd3; end
      tick();
      if (div_ack[0]) begin ack_n++; ack_e = k; end
      if (ce[0]) ce_n++;
    end
    div_load = '0;
    check_int("collision_ack_count", ack_n, 1);
    check_int("collision_ack_edge", ack_e, 4);
    check_int("collision_ce_count", ce_n, 5);

    // Odd divisor 5 on ch1; load of 0 on ch0 exactly on its wrap edge;
    // later load of 1 on ch1 clamps to 2.
    apply_reset();
    ack_e = 0; ack1_e = 0; hi_n = 0; ce_n = 0; ce1_n = 0;
    for (int k = 1; k <= 20; k++) begin
      div_load = '0;
      if (k == 1)  begin div_load[1] = 1'b1; div_value[2*DW-1:DW] = 8'd5; end
      if (k == 4)  begin div_load[0] = 1'b1; div_value[DW-1:0] = 8'd0; end
      if (k == 10) begin div_load[1] = 1'b1; div_value[2*DW-1:DW] = 8'd1; end
      tick();
      if (div_ack[0] && ack_e == 0) ack_e = k;
      if (div_ack[1] && ack1_e == 0) ack1_e = k;
      if (k >= 4 && k <= 13 && clkout[1]) hi_n++;
      if (k >= 9 && k <= 16 && ce[0]) ce_n++;
      if (k >= 15 && k <= 20 && ce[1]) ce1_n++;
    end
    div_load = '0;
    check_int("odd5_ack_edge", ack1_e, 4);
    check_int("odd5_high_cycles", hi_n, 6);
    check_int("wrap_load_ack_edge", ack_e, 8);
    check_int("clamp0_ce_count", ce_n, 4);
    check_int("clamp1_ce_count", ce1_n, 3);

    // Calib on ch0 held high from edge 2 through edge 11: at most one slip.
    apply_reset();
    ce_e1 = 0; ce_e2 = 0; ch1_ce = 0;
    for (int k = 1; k <= 14; k++) begin
      calib[0] = (k >= 2 && k <= 11);
      tick();
      if (ce[0]) begin
        if (ce_e1 == 0) ce_e1 = k;
        else if (ce_e2 == 0) ce_e2 = k;
      end
      if (ce[1] && ch1_ce == 0) ch1_ce = k;
    end
    calib = '0;
    check_int("calib_first_ce", ce_e1, CAL_EN ? 4 : 3);
    check_int("calib_second_ce", ce_e2, CAL_EN ? 8 : 7);
    check_int("calib_other_chan_ce", ch1_ce, 3);

    // Reset while a load is pending with cnt=2: pending is dropped.
    apply_reset();
    div_load[0] = 1'b1;
    div_value[DW-1:0] = 8'd7;
    tick();
    div_load = '0;
    tick();
    check("mid_pending_before_reset", div_pending, 2'b01);
    apply_reset();
    ack_n = 0; ce_e1 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (|div_ack) ack_n++;
      if (ce[0] && ce_e1 == 0) ce_e1 = k;
    end
    check_int("post_reset_ack_count", ack_n, 0);
    check_int("post_reset_first_ce", ce_e1, 3);

    // Randomized loads, divisor values and calib toggles against the model.
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < CH; c++) begin
        div_load[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0)
          div_value[c*DW +: DW] = DW'($urandom_range(0, 255));
        else
          div_value[c*DW +: DW] = DW'($urandom_range(0, 12));
        if ($urandom_range(0, 5) == 0) calib[c] = ~calib[c];
      end
      tick();
    end
    div_load = '0;
    calib    = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Fabric-based, parametrised successor to the fixed divide-by-4 hard clock divider.
- Generates CHANNELS independent divided outputs from one fast clock. Each channel has a runtime-programmable divisor, a glitch-free ratio change applied only at the period boundary, and a phase-slip calibration input.
- Each channel drives a registered divided clock and a single-cycle clock-enable pulse.
- Used to derive pixel/serial-rate enables from the HDMI fast clock.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- DIV_W, 8, divisor width in bits. Maximum divisor is 2^DIV_W-1.
- DEFAULT_DIV, 4, active divisor of every channel after reset. Must be >=2 and <2^DIV_W.

Ports:
- hclkin  in  1  fast input clock; sole clock of the block.
- resetn  in  1  asynchronous, active-low reset.
- div_value  in  CHANNELS*DIV_W  requested divisor; channel i uses bits [i*DIV_W +: DIV_W].
- div_load  in  CHANNELS  per-channel strobe that captures div_value.
- calib  in  CHANNELS  per-channel phase-slip request; rising-edge sensitive.
- clkout  out  CHANNELS  registered divided clock.
- ce  out  CHANNELS  one-hclkin-cycle enable pulse, once per divided period.
- div_ack  out  CHANNELS  one-cycle pulse when a pending divisor becomes active.
- div_pending  out  CHANNELS  high while a loaded divisor awaits application.

Behaviour:
- Reset: all registers clear asynchronously on resetn low.
  - Values: cnt=0, active=DEFAULT_DIV, pending_valid=0, clkout=0, ce=0, div_ack=0, calib edge register=0.
  - Release is synchronous to hclkin.
  - Reset asserted mid-operation aborts any pending load; pending is discarded, with no ack.
- Per channel, with N = active divisor and H = (N+1)>>1:
  - cnt counts 0..N-1 and wraps to 0.
  - clkout is registered: clkout = (cnt < H) for the value cnt holds that cycle. Even N gives 50% duty; odd N is high one cycle longer.
  - ce = 1 exactly in the cycle where cnt == N-1. Registered, no combinational path from inputs.
- Divisor clamp: div_value < 2 is treated as 2.
- Load handshake:
  - div_load high at an edge: pending <= clamped div_value, pending_valid <= 1. A second load before application overwrites pending (last wins).
  - Application happens at the wrap edge (cnt == N-1 -> 0) when pending_valid=1: active <= pending, pending_valid <= 0, div_ack = 1 for the first cycle of the new period.
  - Load coincident with a wrap edge: any previously pending value is applied at that wrap; the new value becomes pending and applies at the following wrap.
  - div_pending mirrors pending_valid.
- Calibration:
  - A rising edge of calib (sampled, registered) causes cnt to hold for exactly one cycle.
  - During that cycle clkout holds its level and ce is forced to 0; the whole phase shifts one hclkin cycle later.
  - Calib hold on the cnt == N-1 cycle delays the wrap and any pending application by one cycle.
  - Calib held high produces only one slip; it must return low before the next slip.
- Channels are fully independent; no cross-channel phase relationship is guaranteed after differing loads or calibs.
- Latency: div_load to new-ratio effect ranges from 1 to N+1 cycles.

Optional Feature:
- Macro: CLKDIV_MULTI_CALIB_EN.
- Defined: calib behaves as above.
- Undefined: calib port remains present but is ignored. No edge register or hold logic is synthesised; cnt never holds.

Decomposition:
- Package clkdiv_multi_pkg:
  - DIV_W default, DEFAULT_DIV.
  - Function clamp_div(value) -> max(value, 2).
  - Function high_len(N) -> (N+1)>>1.
- Sub-module clkdiv_multi_chan: one channel (counter, pending register, calib logic).
- Top clkdiv_multi generates CHANNELS instances and slices div_value.

Test Plan:
- Reset, defaults, CHANNELS=2, no loads:
  - Release resetn -> clkout per cycle 1,0,0,1,1,0,0,...
  - ce high on cycles 3,7,11 after release, on both channels.
- Ratio change: load 6 on ch0 mid-period -> div_pending=1 until the wrap, div_ack one cycle, then clkout 3 high / 3 low, ce every 6 cycles. Ch1 unaffected.
- Odd divisor and clamps:
  - Load 5 -> clkout 3 high / 2 low.
  - Load 0 or 1 -> behaves as 2: clkout toggles every cycle, ce every cycle 2.
- Load collisions:
  - Two loads, 8 then 3, inside one period -> only 3 applied, single div_ack.
  - Load asserted exactly on the wrap edge -> applied one period later.
- Calibration (macro defined, N=4):
  - One calib pulse -> next ce delayed by 1 cycle, clkout high phase stretched 1 cycle.
  - Calib held high 10 cycles -> only one slip.
  - Macro undefined -> no slip.
- Reset mid-operation: assert resetn low while pending_valid=1 with cnt=2 -> all outputs 0 immediately. After release, divisor is DEFAULT_DIV and no div_ack is produced.
